mem_bus_master: RTL and testbench

// - CPU-side master for the shared-bus RAM. Turns single-word CPU requests (req/ack) into
//   RAM bus cycles on the bidirectional data bus: address, write strobe, data drive and turnaround.
// - Sits between the CPU datapath/control and the RAM. It is the only other driver of the

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_wait_counter.sv | 26 ++
 rtl/mem_bus_master.sv | 139 +++++++++++++
 tb/tb_mem_bus_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default sizing for the CPU-side shared-bus RAM master.
package mem_bus_pkg;

  localparam int DWIDTH_DEF         = 32;
  localparam int AWIDTH_DEF         = 10;
  localparam int RD_WAIT_CYCLES_DEF = 5;
  localparam int TURN_CYCLES_DEF    = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_REL,
    WR_DRV,
    TURN
  } state_e;

  // Width of a down-counter able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that stops at 1; done flags the final cycle of a wait.
module mem_wait_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q > CW'(1)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_bus_master.sv
// CPU request/ack to shared-bus RAM cycles, including bus release and turnaround.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int AWIDTH         = AWIDTH_DEF,
  parameter int RD_WAIT_CYCLES = RD_WAIT_CYCLES_DEF,
  parameter int TURN_CYCLES    = TURN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_wr,
  inout  wire  [DWIDTH-1:0] ram_data
);

  localparam int CW = cnt_width(RD_WAIT_CYCLES);

  state_e            state_q;
  logic [AWIDTH-1:0] ram_addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              ram_wr_q;
  logic              drv_en_q;
  logic              ack_q;
  logic              busy_q;

  logic              cnt_load_d;
  logic [CW-1:0]     cnt_val_d;
  logic              cnt_done;

  // The counter must already hold the wait length on the first cycle of a state,
  // so it is loaded on the edge that enters that state.
  always_comb begin
    cnt_load_d = 1'b0;
    cnt_val_d  = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_load_d = 1'b1;
          cnt_val_d  = CW'(RD_WAIT_CYCLES);
        end
      end
      WR_DRV: begin
        cnt_load_d = 1'b1;
        cnt_val_d  = CW'(TURN_CYCLES);
      end
      default: ;
    endcase
  end

  mem_wait_counter #(
    .CW(CW)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load_d),
    .load_val_i(cnt_val_d),
    .done_o    (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_wr_q   <= 1'b0;
      drv_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            ram_addr_q <= addr;
            wdata_q    <= wdata;
            busy_q     <= 1'b1;
            if (we) begin
              ram_wr_q <= 1'b1;
              state_q  <= WR_REL;
            end else begin
              state_q  <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_done) begin
            rdata_q <= ram_data;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        WR_REL: begin
          // RAM has had the full access time to float the bus before we drive it.
          if (cnt_done) begin
            drv_en_q <= 1'b1;
            state_q  <= WR_DRV;
          end
        end
        WR_DRV: begin
          drv_en_q <= 1'b0;
          ram_wr_q <= 1'b0;
          state_q  <= TURN;
        end
        TURN: begin
          if (cnt_done) begin
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          drv_en_q <= 1'b0;
          ram_wr_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ram_data = drv_en_q ? wdata_q : 'z;
  assign ram_addr = ram_addr_q;
  assign ram_wr   = ram_wr_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with a behavioural shared-bus RAM.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  wire  [DW-1:0] ram_data;

  always #5 clk = ~clk;

  mem_bus_master dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .busy    (busy),
    .ram_addr(ram_addr),
    .ram_wr  (ram_wr),
    .ram_data(ram_data)
  );

  // RAM model: drives mem[ram_addr] while ram_wr=0, captures the bus each edge while ram_wr=1.
  logic [DW-1:0] mem [0:1023];
  assign ram_data = ram_wr ? 'z : mem[ram_addr];
  always @(posedge clk) begin
    if (rst) mem[100] <= 32'hC000_0001;
    else if (ram_wr) mem[ram_addr] <= ram_data;
  end

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            due;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] model [int];
  int            ack_cyc_q[$];
  int            cyc = 0;
  int            n_ack = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    if (a == AW'(100)) return 32'hC000_0001;
    return 'x;
  endfunction

  // Acceptance: request sampled at an edge while the master reports idle.
  always @(posedge clk) begin
    txn_t t;
    cyc = cyc + 1;
    if (!rst && req && !busy) begin
      t.w   = we;
      t.a   = addr;
      t.due = cyc + (we ? 7 : 5);
      if (we) begin
        t.d = wdata;
        model[int'(addr)] = wdata;
      end else begin
        t.d = exp_read(addr);
      end
      sb.push_back(t);
      $display("accept  cyc=%0d we=%0d addr=%0d data=%h", cyc, we, addr, t.d);
    end
  end

  // Completion monitor and per-cycle bus rules.
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      sb.delete();
      last_rd = '0;
    end else begin
      chk("contention", 64'(dut.drv_en_q && !ram_wr), 64'(0));
      if (ack) begin
        n_ack++;
        ack_cyc_q.push_back(cyc);
        chk("bus_x_on_ack", 64'($isunknown(ram_data)), 64'(0));
        if (sb.size() == 0) begin
          chk("spurious_ack", 64'(1), 64'(0));
        end else begin
          t = sb.pop_front();
          chk("ack_time", 64'(cyc), 64'(t.due));
          if (!t.w) begin
            chk("rdata", 64'(rdata), 64'(t.d));
            last_rd = t.d;
          end else begin
            chk("rdata_held", 64'(rdata), 64'(last_rd));
          end
          $display("ack     cyc=%0d we=%0d addr=%0d rdata=%h", cyc, t.w, t.a, rdata);
        end
      end
    end
  end

  task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit hold);
    int k;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack) break;
    end
    if (k == 30) chk("ack_timeout", 64'(0), 64'(1));
    #1;
    if (!hold) req = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int k;
    int acks_before;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ram_wr", 64'(ram_wr), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_drv_en", 64'(dut.drv_en_q), 64'(0));
    @(negedge clk);
    #1 rst = 1'b0;

    // Write then read back.
    cpu_op(1'b1, 10'd16, 32'h0000_0007, 1'b0);
    cpu_op(1'b0, 10'd16, '0, 1'b0);

    // Preloaded read: busy for exactly RD_WAIT cycles, single-cycle ack.
    req = 1'b1; we = 1'b0; addr = 10'd100;
    busy_cnt = 0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack) break;
      if (busy) busy_cnt++;
    end
    if (k == 30) chk("ack_timeout", 64'(0), 64'(1));
    #1 req = 1'b0;
    chk("rd_busy_cycles", 64'(busy_cnt), 64'(5));
    @(negedge clk);
    chk("ack_single", 64'(ack), 64'(0));
    #1;

    // Back-to-back writes with req held, then read both back.
    cpu_op(1'b1, 10'd3, 32'hA5A5_A5A5, 1'b1);
    cpu_op(1'b1, 10'd4, 32'h5A5A_5A5A, 1'b0);
    chk("b2b_gap", 64'(ack_cyc_q[ack_cyc_q.size()-1] - ack_cyc_q[ack_cyc_q.size()-2]), 64'(8));
    cpu_op(1'b0, 10'd3, '0, 1'b0);
    cpu_op(1'b0, 10'd4, '0, 1'b0);

    // Request pulsed while busy must be ignored.
    acks_before = n_ack;
    req = 1'b1; we = 1'b0; addr = 10'd100;
    @(negedge clk); #1 req = 1'b0;
    @(negedge clk); #1 req = 1'b1; we = 1'b1; addr = 10'd16; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("addr_stable", 64'(ram_addr), 64'(100));
    #1 req = 1'b0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack) break;
    end
    if (k == 30) chk("ack_timeout", 64'(0), 64'(1));
    repeat (10) @(negedge clk);
    chk("ignored_one_ack", 64'(n_ack - acks_before), 64'(1));
    chk("sb_empty_mid", 64'(sb.size()), 64'(0));
    #1;

    // Reset during WR_DRV: bus released and strobe low without waiting for a clock edge.
    acks_before = n_ack;
    req = 1'b1; we = 1'b1; addr = 10'd50; wdata = 32'h1234_5678;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (dut.state_q == WR_DRV) break;
    end
    chk("reach_wr_drv", 64'(dut.state_q == WR_DRV), 64'(1));
    #1 rst = 1'b1; req = 1'b0;
    #1;
    chk("rst_mid_drv_en", 64'(dut.drv_en_q), 64'(0));
    chk("rst_mid_ram_wr", 64'(ram_wr), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_ack", 64'(n_ack - acks_before), 64'(0));
    chk("rst_state_idle", 64'(dut.state_q == IDLE), 64'(1));
    chk("rst_busy_after", 64'(busy), 64'(0));

    // Master still works after the aborted cycle.
    #1;
    cpu_op(1'b0, 10'd4, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty_end", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
